// File: rtl/colour_bbox_tracker.sv
// colour_bbox_tracker: per-frame bounding box of run-qualified detected pixels, RGB pass-through with one register stage.
// Optional overlay of the previous frame's box is compiled in when BBOX_OVERLAY_EN is defined.
module colour_bbox_tracker #(
    parameter int LINE_WIDTH = 640,
    parameter int ROW_NUMBER = 480,
    parameter int RUN_LEN    = 3,
    parameter int MIN_PIXELS = 16
`ifdef BBOX_OVERLAY_EN
    ,
    parameter logic [23:0] BOX_COLOUR = 24'hFF0000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_detect,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [23:0] out_rgb,
    output logic        bbox_valid,
    output logic        bbox_found,
    output logic        bbox_err,
    output logic [15:0] bbox_min_x,
    output logic [15:0] bbox_max_x,
    output logic [15:0] bbox_min_y,
    output logic [15:0] bbox_max_y,
    output logic [19:0] bbox_count
);
    localparam logic [15:0] X_LAST = 16'(LINE_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(ROW_NUMBER - 1);
    localparam logic [3:0]  RUN_Q  = 4'(RUN_LEN);
    localparam logic [15:0] RUN_M1 = 16'(RUN_LEN - 1);
    localparam logic [19:0] MIN_C  = 20'(MIN_PIXELS);

    logic        out_valid_q, out_sop_q, out_eop_q;
    logic [23:0] out_rgb_q, rgb_d;
    logic [15:0] x_q, y_q, px, py;
    logic [3:0]  run_q, run_base, run_d;
    logic        active_q, live, qual, found_d;
    logic [15:0] min_x_q, max_x_q, min_y_q, max_y_q;
    logic [15:0] a_min_x, a_max_x, a_min_y, a_max_y, cand_x;
    logic [15:0] min_x_d, max_x_d, min_y_d, max_y_d;
    logic [19:0] count_q, a_count, count_d;
    logic        bbox_valid_q, bbox_found_q, bbox_err_q;
    logic [15:0] bbox_min_x_q, bbox_max_x_q, bbox_min_y_q, bbox_max_y_q;
    logic [19:0] bbox_count_q;
    logic        xfer;

    assign in_ready   = out_ready || !out_valid_q;
    assign xfer       = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign out_sop    = out_sop_q;
    assign out_eop    = out_eop_q;
    assign out_rgb    = out_rgb_q;
    assign bbox_valid = bbox_valid_q;
    assign bbox_found = bbox_found_q;
    assign bbox_err   = bbox_err_q;
    assign bbox_min_x = bbox_min_x_q;
    assign bbox_max_x = bbox_max_x_q;
    assign bbox_min_y = bbox_min_y_q;
    assign bbox_max_y = bbox_max_y_q;
    assign bbox_count = bbox_count_q;

    // Position of the current pixel, run qualification and the accumulator update it would cause
    always_comb begin
        px       = in_sop ? 16'd0 : x_q;
        py       = in_sop ? 16'd0 : y_q;
        live     = in_sop || active_q;
        run_base = (px == 16'd0) ? 4'd0 : run_q;
        run_d    = !in_detect ? 4'd0 : (run_base == RUN_Q ? RUN_Q : run_base + 4'd1);
        qual     = live && in_detect && (run_d == RUN_Q);
        a_min_x  = in_sop ? 16'hFFFF : min_x_q;
        a_max_x  = in_sop ? 16'd0 : max_x_q;
        a_min_y  = in_sop ? 16'hFFFF : min_y_q;
        a_max_y  = in_sop ? 16'd0 : max_y_q;
        a_count  = in_sop ? 20'd0 : count_q;
        cand_x   = px - RUN_M1;
        min_x_d  = (qual && cand_x < a_min_x) ? cand_x : a_min_x;
        max_x_d  = (qual && px > a_max_x) ? px : a_max_x;
        min_y_d  = (qual && py < a_min_y) ? py : a_min_y;
        max_y_d  = (qual && py > a_max_y) ? py : a_max_y;
        count_d  = (qual && a_count != 20'hFFFFF) ? a_count + 20'd1 : a_count;
        found_d  = count_d >= MIN_C;
    end

`ifdef BBOX_OVERLAY_EN
    logic on_edge;
    // Paint the previously published box edge over the passing pixel
    always_comb begin
        on_edge = bbox_found_q &&
                  (((px == bbox_min_x_q || px == bbox_max_x_q) && py >= bbox_min_y_q && py <= bbox_max_y_q) ||
                   ((py == bbox_min_y_q || py == bbox_max_y_q) && px >= bbox_min_x_q && px <= bbox_max_x_q));
        rgb_d   = on_edge ? BOX_COLOUR : in_rgb;
    end
`else
    assign rgb_d = in_rgb;
`endif

    // Output register stage, position/run tracking, accumulation and end-of-frame publish
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_rgb_q    <= 24'd0;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            run_q        <= 4'd0;
            active_q     <= 1'b0;
            min_x_q      <= 16'hFFFF;
            max_x_q      <= 16'd0;
            min_y_q      <= 16'hFFFF;
            max_y_q      <= 16'd0;
            count_q      <= 20'd0;
            bbox_valid_q <= 1'b0;
            bbox_found_q <= 1'b0;
            bbox_err_q   <= 1'b0;
            bbox_min_x_q <= 16'd0;
            bbox_max_x_q <= 16'd0;
            bbox_min_y_q <= 16'd0;
            bbox_max_y_q <= 16'd0;
            bbox_count_q <= 20'd0;
        end else begin
            bbox_valid_q <= 1'b0;
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_sop_q   <= in_sop;
                out_eop_q   <= in_eop;
                out_rgb_q   <= rgb_d;
                x_q         <= (px == X_LAST) ? 16'd0 : px + 16'd1;
                y_q         <= (px == X_LAST && py != Y_LAST) ? py + 16'd1 : py;
                run_q       <= run_d;
                active_q    <= live && !in_eop;
                if (live && in_eop) begin
                    bbox_valid_q <= 1'b1;
                    bbox_found_q <= found_d;
                    bbox_err_q   <= !(px == X_LAST && py == Y_LAST);
                    bbox_min_x_q <= found_d ? min_x_d : 16'd0;
                    bbox_max_x_q <= found_d ? max_x_d : 16'd0;
                    bbox_min_y_q <= found_d ? min_y_d : 16'd0;
                    bbox_max_y_q <= found_d ? max_y_d : 16'd0;
                    bbox_count_q <= count_d;
                    min_x_q      <= 16'hFFFF;
                    max_x_q      <= 16'd0;
                    min_y_q      <= 16'hFFFF;
                    max_y_q      <= 16'd0;
                    count_q      <= 20'd0;
                end else begin
                    min_x_q <= min_x_d;
                    max_x_q <= max_x_d;
                    min_y_q <= min_y_d;
                    max_y_q <= max_y_d;
                    count_q <= count_d;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_colour_bbox_tracker.sv
// tb_colour_bbox_tracker: directed frames with hand-computed bounding box results on a reduced 120x64 frame.
module tb_colour_bbox_tracker;
    localparam int LW = 120;
    localparam int RN = 64;
    localparam int NPIX = LW * RN;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_detect = 1'b0;
    logic [23:0] in_rgb = 24'd0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_sop, out_eop;
    logic [23:0] out_rgb;
    logic        bbox_valid, bbox_found, bbox_err;
    logic [15:0] bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
    logic [19:0] bbox_count;

    int checks = 0;
    int errors = 0;
    int beats = 0;
    int bv_cnt = 0;
    longint rgb_sum = 0;
    int log_idx = 0;
    logic [23:0] out_log [NPIX];

    colour_bbox_tracker #(.LINE_WIDTH(LW), .ROW_NUMBER(RN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop), .in_eop(in_eop),
        .in_detect(in_detect), .in_rgb(in_rgb),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_rgb(out_rgb),
        .bbox_valid(bbox_valid), .bbox_found(bbox_found), .bbox_err(bbox_err),
        .bbox_min_x(bbox_min_x), .bbox_max_x(bbox_max_x),
        .bbox_min_y(bbox_min_y), .bbox_max_y(bbox_max_y),
        .bbox_count(bbox_count)
    );

    always #5 clk = ~clk;

    // Output beat counter, rgb checksum, per-frame log and bbox_valid pulse counter
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            beats   <= beats + 1;
            rgb_sum <= rgb_sum + longint'(out_rgb);
            if (out_sop) begin
                out_log[0] <= out_rgb;
                log_idx    <= 1;
            end else begin
                if (log_idx < NPIX) out_log[log_idx] <= out_rgb;
                log_idx <= log_idx + 1;
            end
        end
        if (bbox_valid) bv_cnt <= bv_cnt + 1;
    end

    function automatic logic [23:0] pix_rgb(input int x, input int y);
        logic [23:0] r;
        r = {x[7:0], y[7:0], 8'h5A};
        return r;
    endfunction

    function automatic logic det(input int pat, input int x, input int y);
        case (pat)
            1: return x >= 100 && x <= 109 && y >= 50 && y <= 59;
            2: return (y == 5 && (x == 10 || x == 11)) || (y == 20 && (x == 40 || x == 41)) ||
                      (y == 40 && x >= LW - 2) || (y == 41 && x <= 1);
            3: return x >= 20 && x <= 29 && y < 8;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_px(input logic sop, input logic eop, input logic d, input logic [23:0] rgb);
        int guard;
        in_valid = 1'b1; in_sop = sop; in_eop = eop; in_detect = d; in_rgb = rgb;
        #1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL drive_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_frame(input int npix, input int pat, input logic has_eop);
        @(negedge clk);
        for (int i = 0; i < npix; i++)
            drive_px(i == 0, has_eop && i == npix - 1, det(pat, i % LW, i / LW), pix_rgb(i % LW, i / LW));
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_detect = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if ({bbox_valid, bbox_found, bbox_err, bbox_count} !== 23'd0) begin errors++; $display("FAIL reset_bbox flags/count got=%0h exp=0", {bbox_valid, bbox_found, bbox_err, bbox_count}); end
        checks++; if (out_rgb !== 24'd0) begin errors++; $display("FAIL reset_out_rgb got=%0h exp=0", out_rgb); end
        rst = 1'b1;
    endtask

    task automatic test_empty;
        int b0 = bv_cnt;
        run_frame(NPIX, 0, 1'b1);
        #1;
        checks++; if (bbox_valid !== 1'b1) begin errors++; $display("FAIL empty_valid_pulse got=%0b exp=1", bbox_valid); end
        @(negedge clk); #1;
        checks++; if (bbox_valid !== 1'b0) begin errors++; $display("FAIL empty_valid_one_cycle got=%0b exp=0", bbox_valid); end
        repeat (3) @(negedge clk);
        checks++; if (bv_cnt - b0 !== 1) begin errors++; $display("FAIL empty_pulse_count got=%0d exp=1", bv_cnt - b0); end
        checks++; if ({bbox_found, bbox_err} !== 2'b00) begin errors++; $display("FAIL empty_found_err got=%b exp=00", {bbox_found, bbox_err}); end
        checks++; if (bbox_count !== 20'd0) begin errors++; $display("FAIL empty_count got=%0d exp=0", bbox_count); end
        checks++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== 64'd0) begin errors++; $display("FAIL empty_corners got=%0h exp=0", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}); end
    endtask

    task automatic test_box;
        int b0 = bv_cnt;
        run_frame(NPIX, 1, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (bv_cnt - b0 !== 1) begin errors++; $display("FAIL box_pulse_count got=%0d exp=1", bv_cnt - b0); end
        checks++; if ({bbox_found, bbox_err} !== 2'b10) begin errors++; $display("FAIL box_found_err got=%b exp=10", {bbox_found, bbox_err}); end
        checks++; if (bbox_min_x !== 16'd100 || bbox_max_x !== 16'd109) begin errors++; $display("FAIL box_x got=%0d..%0d exp=100..109", bbox_min_x, bbox_max_x); end
        checks++; if (bbox_min_y !== 16'd50 || bbox_max_y !== 16'd59) begin errors++; $display("FAIL box_y got=%0d..%0d exp=50..59", bbox_min_y, bbox_max_y); end
        checks++; if (bbox_count !== 20'd80) begin errors++; $display("FAIL box_count got=%0d exp=80", bbox_count); end
    endtask

    task automatic test_speckle;
        run_frame(NPIX, 2, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (bbox_count !== 20'd0) begin errors++; $display("FAIL speckle_count got=%0d exp=0", bbox_count); end
        checks++; if (bbox_found !== 1'b0 || bbox_min_x !== 16'd0) begin errors++; $display("FAIL speckle_found got=%0b min_x=%0d exp=0/0", bbox_found, bbox_min_x); end
    endtask

    task automatic test_stall;
        localparam int S = 55 * LW + 104;
        int b0 = beats;
        longint s0 = rgb_sum;
        longint exp_sum = 0;
        logic [23:0] s_rgb;
        logic s_sop, s_eop;
        @(negedge clk);
        for (int i = 0; i < NPIX; i++) begin
            exp_sum += longint'(pix_rgb(i % LW, i / LW));
            if (i == S) begin
                out_ready = 1'b0;
                in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_detect = det(1, i % LW, i / LW); in_rgb = pix_rgb(i % LW, i / LW);
                #1;
                s_rgb = out_rgb; s_sop = out_sop; s_eop = out_eop;
                checks++; if (s_rgb !== pix_rgb(103, 55)) begin errors++; $display("FAIL stall_prev_rgb got=%0h exp=%0h", s_rgb, pix_rgb(103, 55)); end
                for (int k = 0; k < 5; k++) begin
                    @(posedge clk); @(negedge clk); #1;
                    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
                    checks++; if ({out_valid, out_rgb, out_sop, out_eop} !== {1'b1, s_rgb, s_sop, s_eop}) begin errors++; $display("FAIL stall_hold cyc=%0d got=%0h exp=%0h", k, {out_valid, out_rgb, out_sop, out_eop}, {1'b1, s_rgb, s_sop, s_eop}); end
                end
                out_ready = 1'b1;
            end
            drive_px(i == 0, i == NPIX - 1, det(1, i % LW, i / LW), pix_rgb(i % LW, i / LW));
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_detect = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (beats - b0 !== NPIX) begin errors++; $display("FAIL stall_beats got=%0d exp=%0d", beats - b0, NPIX); end
        checks++; if (rgb_sum - s0 !== exp_sum) begin errors++; $display("FAIL stall_rgb_sum got=%0d exp=%0d", rgb_sum - s0, exp_sum); end
        checks++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {16'd100, 16'd109, 16'd50, 16'd59}) begin errors++; $display("FAIL stall_corners got=%0h exp=%0h", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}, {16'd100, 16'd109, 16'd50, 16'd59}); end
        checks++; if (bbox_count !== 20'd80) begin errors++; $display("FAIL stall_count got=%0d exp=80", bbox_count); end
    endtask

    task automatic test_err;
        int b0 = bv_cnt;
        run_frame(3 * LW + 11, 0, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (bv_cnt - b0 !== 1) begin errors++; $display("FAIL err_pulse_count got=%0d exp=1", bv_cnt - b0); end
        checks++; if (bbox_err !== 1'b1) begin errors++; $display("FAIL err_flag got=%0b exp=1", bbox_err); end
        checks++; if (bbox_found !== 1'b0) begin errors++; $display("FAIL err_found got=%0b exp=0", bbox_found); end
    endtask

    task automatic test_midsop;
        int b0 = bv_cnt;
        run_frame(1000, 3, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (bv_cnt !== b0) begin errors++; $display("FAIL midsop_no_pulse got=%0d exp=%0d", bv_cnt, b0); end
        run_frame(NPIX, 1, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (bv_cnt - b0 !== 1) begin errors++; $display("FAIL midsop_pulse_count got=%0d exp=1", bv_cnt - b0); end
        checks++; if ({bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y} !== {16'd100, 16'd109, 16'd50, 16'd59}) begin errors++; $display("FAIL midsop_corners got=%0h exp=%0h", {bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}, {16'd100, 16'd109, 16'd50, 16'd59}); end
        checks++; if ({bbox_found, bbox_err, bbox_count} !== {2'b10, 20'd80}) begin errors++; $display("FAIL midsop_found_err_count got=%0h exp=%0h", {bbox_found, bbox_err, bbox_count}, {2'b10, 20'd80}); end
    endtask

    task automatic test_overlay;
        logic [23:0] e_edge, e_in;
        run_frame(NPIX, 1, 1'b1);
        repeat (3) @(negedge clk);
`ifdef BBOX_OVERLAY_EN
        e_edge = 24'hFF0000;
`else
        e_edge = 24'h000000;
`endif
        e_in = pix_rgb(100, 50);
        checks++; if (out_log[50 * LW + 100] !== (e_edge != 0 ? e_edge : e_in)) begin errors++; $display("FAIL overlay_100_50 got=%0h exp=%0h", out_log[50 * LW + 100], (e_edge != 0 ? e_edge : e_in)); end
        e_in = pix_rgb(109, 55);
        checks++; if (out_log[55 * LW + 109] !== (e_edge != 0 ? e_edge : e_in)) begin errors++; $display("FAIL overlay_109_55 got=%0h exp=%0h", out_log[55 * LW + 109], (e_edge != 0 ? e_edge : e_in)); end
        e_in = pix_rgb(105, 59);
        checks++; if (out_log[59 * LW + 105] !== (e_edge != 0 ? e_edge : e_in)) begin errors++; $display("FAIL overlay_105_59 got=%0h exp=%0h", out_log[59 * LW + 105], (e_edge != 0 ? e_edge : e_in)); end
        checks++; if (out_log[55 * LW + 105] !== pix_rgb(105, 55)) begin errors++; $display("FAIL overlay_105_55 got=%0h exp=%0h", out_log[55 * LW + 105], pix_rgb(105, 55)); end
    endtask

    task automatic test_midreset;
        run_frame(200, 0, 1'b0);
        rst = 1'b0;
        @(negedge clk); #1;
        checks++; if ({out_valid, out_sop, out_eop, out_rgb} !== 27'd0) begin errors++; $display("FAIL midreset_out got=%0h exp=0", {out_valid, out_sop, out_eop, out_rgb}); end
        checks++; if ({bbox_found, bbox_err, bbox_count, bbox_max_x, bbox_max_y} !== 54'd0) begin errors++; $display("FAIL midreset_bbox got=%0h exp=0", {bbox_found, bbox_err, bbox_count, bbox_max_x, bbox_max_y}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_empty;
        test_box;
        test_speckle;
        test_stall;
        test_err;
        test_midsop;
        test_overlay;
        test_midreset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
